// File: rtl/ibex_bist_apb_sequencer.sv
// Autonomous APB initiator that launches the ALU BIST after an idle interval and core sleep, then polls for a verdict.
// Optional feature macro: BIST_SEQ_TIMEOUT_EN (poll-count and access-stall limits).
module ibex_bist_apb_sequencer #(
  parameter int          PERIOD      = 1024,
  parameter logic [31:0] CTRL_ADDR   = 32'h0000_0000,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_0004,
  parameter int          POLL_LIMIT  = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        trig_i,
  input  logic        core_sleep_i,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  output logic        busy_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [15:0] run_count_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SLEEP,
    WR_SETUP,
    WR_ACCESS,
    RD_SETUP,
    RD_ACCESS,
    EVAL
  } state_e;

  localparam logic [31:0] PERIOD_M1 = 32'(PERIOD - 1);

  state_e      state;
  logic [31:0] ivl_cnt;
  logic        trig_run;
  logic [2:0]  status;

  // Only the three status flags of the wrapper are meaningful.
  logic unused_prdata;
  assign unused_prdata = ^prdata_i[31:3];

  assign busy_o = (state != IDLE) && (state != WAIT_SLEEP);

`ifdef BIST_SEQ_TIMEOUT_EN
  localparam logic [31:0] POLL_MAX = 32'(POLL_LIMIT);
  logic [31:0] poll_cnt;
  logic [5:0]  stall_cnt;
  logic        timeout_q;
  assign timeout_o = timeout_q;
`else
  localparam int unused_poll_limit = POLL_LIMIT;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ivl_cnt     <= '0;
      trig_run    <= 1'b0;
      status      <= '0;
      paddr_o     <= '0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      run_count_o <= '0;
`ifdef BIST_SEQ_TIMEOUT_EN
      poll_cnt    <= '0;
      stall_cnt   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A trigger landing on the expiry cycle is the same single start.
          if (trig_i || (enable_i && ivl_cnt == PERIOD_M1)) begin
            state    <= WAIT_SLEEP;
            ivl_cnt  <= '0;
            trig_run <= trig_i;
          end else if (enable_i) begin
            ivl_cnt <= ivl_cnt + 32'd1;
          end else begin
            ivl_cnt <= '0;
          end
        end
        WAIT_SLEEP: begin
          if (!enable_i && !trig_run && !trig_i) begin
            state <= IDLE;
          end else if (core_sleep_i) begin
            state     <= WR_SETUP;
            paddr_o   <= CTRL_ADDR;
            pwrite_o  <= 1'b1;
            pwdata_o  <= 32'h1;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            pass_o    <= 1'b0;
            fail_o    <= 1'b0;
`ifdef BIST_SEQ_TIMEOUT_EN
            timeout_q <= 1'b0;
            poll_cnt  <= '0;
            stall_cnt <= '0;
`endif
          end else if (trig_i) begin
            trig_run <= 1'b1;
          end
        end
        WR_SETUP: begin
          state     <= WR_ACCESS;
          penable_o <= 1'b1;
        end
        WR_ACCESS: begin
          if (pready_i) begin
            state     <= RD_SETUP;
            paddr_o   <= STATUS_ADDR;
            pwrite_o  <= 1'b0;
            pwdata_o  <= '0;
            penable_o <= 1'b0;
`ifdef BIST_SEQ_TIMEOUT_EN
            stall_cnt <= '0;
          end else if (stall_cnt == 6'd63) begin
            state       <= IDLE;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            fail_o      <= 1'b1;
            pass_o      <= 1'b0;
            timeout_q   <= 1'b1;
            run_count_o <= run_count_o + 16'd1;
          end else begin
            stall_cnt <= stall_cnt + 6'd1;
`endif
          end
        end
        RD_SETUP: begin
          state     <= RD_ACCESS;
          penable_o <= 1'b1;
        end
        RD_ACCESS: begin
          if (pready_i) begin
            state     <= EVAL;
            status    <= prdata_i[2:0];
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
`ifdef BIST_SEQ_TIMEOUT_EN
            poll_cnt  <= poll_cnt + 32'd1;
            stall_cnt <= '0;
          end else if (stall_cnt == 6'd63) begin
            state       <= IDLE;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            fail_o      <= 1'b1;
            pass_o      <= 1'b0;
            timeout_q   <= 1'b1;
            run_count_o <= run_count_o + 16'd1;
          end else begin
            stall_cnt <= stall_cnt + 6'd1;
`endif
          end
        end
        EVAL: begin
          if (status[0]) begin
`ifdef BIST_SEQ_TIMEOUT_EN
            if (poll_cnt >= POLL_MAX) begin
              state       <= IDLE;
              fail_o      <= 1'b1;
              pass_o      <= 1'b0;
              timeout_q   <= 1'b1;
              run_count_o <= run_count_o + 16'd1;
            end else begin
              state     <= RD_SETUP;
              psel_o    <= 1'b1;
              penable_o <= 1'b0;
            end
`else
            state     <= RD_SETUP;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
`endif
          end else begin
            state       <= IDLE;
            pass_o      <= status[1] & ~status[2];
            fail_o      <= status[2] | ~status[1];
            run_count_o <= run_count_o + 16'd1;
`ifdef BIST_SEQ_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
